maxnet_controller: RTL
======================

# maxnet_controller

Sequencing controller for the 4-lane MaxNet array of processing units (the x·w multiply / carry-propagate-add PU). It owns the load and register-enable strobes of every PU: it loads the initial activations, runs multiply/accumulate/write-back iterations, and inspects the per-lane nonzero flags after each write-back. It stops when at most one lane is still active, or when the iteration budget is exhausted. It then reports the winning lane and finishes with a one-cycle done handshake.

## Interface
- NUM_PU, 4, number of PU lanes (winner width is log2(NUM_PU); only 4 is supported).
- MAX_ITER, 31, maximum number of write-back iterations before timeout (1..31).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- nz  input  NUM_PU  per-lane "x register nonzero" flag, combinational from the registered lane activations.
- sel_init  output  1  x-register input mux: 1 selects external initial values, 0 selects PU results.
- ld_x  output  1  load enable for all x registers.
- pen_mult  output  1  enable for the PU multiplier-output registers.
- pen_cpa  output  1  enable for the PU adder-result registers.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at run completion.
- winner  output  2  index of the surviving lane.
- winner_valid  output  1  exactly one lane survived.
- timeout  output  1  run ended by MAX_ITER with two or more lanes active.
- iter_cnt  output  5  completed write-back iterations of the current or last run.

## Operation
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- States: IDLE, LOAD, CHECK, MULT, ADD, WB, DONE.
- All strobes (sel_init, ld_x, pen_mult, pen_cpa) are Moore outputs decoded from the state register, and each is 0 outside the state listed here.
- IDLE: waits for start. With start=1 it clears iter_cnt, winner, winner_valid and timeout, then goes to LOAD.
- LOAD: sel_init=1, ld_x=1, then goes to CHECK.
- CHECK: counts the set bits of nz.
  - Popcount ≤ 1: go to DONE.
  - Otherwise, iter_cnt == MAX_ITER: go to DONE and set timeout.
  - Otherwise: go to MULT.
- MULT: pen_mult=1, then goes to ADD.
- ADD: pen_cpa=1, then goes to WB.
- WB: sel_init=0, ld_x=1, iter_cnt increments (saturates at 31), then goes to CHECK.
- DONE: done=1, then goes to IDLE unconditionally.
- Winner resolution happens on the CHECK→DONE transition and is registered:
  - Popcount == 1: winner = index of the set bit, winner_valid=1.
  - Popcount == 0: winner=0, winner_valid=0, timeout=0.
  - Timeout: winner=0, winner_valid=0.
- winner, winner_valid, timeout and iter_cnt hold their values in IDLE until the next accepted start.
- start is ignored in every state except IDLE; it is not queued.
- nz is sampled only in CHECK, so glitches in other states have no effect.

## Timing
- Reset: state=IDLE. All outputs are 0: sel_init, ld_x, pen_mult, pen_cpa, busy, done, winner, winner_valid, timeout, iter_cnt.
- Reset mid-run aborts on the next edge: strobes drop immediately and no done pulse is issued.
- Cycle numbering: start is sampled high at edge t0. LOAD is active in the cycle after t0, CHECK in the cycle after that, and so on.
- Run of k iterations (k ≥ 0): LOAD (1 cycle), then k × (CHECK, MULT, ADD, WB), then the final CHECK (1 cycle), then DONE (1 cycle).
  - done is high in cycle 3 + 4k after t0 (LOAD = cycle 1).
  - busy is high from cycle 1 through the done cycle inclusive.
- Data timing:
  - The PU multiplier registers capture at the end of MULT.
  - The adder registers capture at the end of ADD.
  - The x registers capture at the end of WB, so nz reflects the new values in the following CHECK.
- Back-to-back runs: start held high during DONE is not accepted. The earliest acceptance is the IDLE cycle after DONE.
- Timeout latency: done at cycle 3 + 4·MAX_ITER, with iter_cnt = MAX_ITER.

## Test plan
- Reset: assert rst for 2 cycles during MULT of a running job → next cycle state=IDLE, busy=0, all strobes 0, no done pulse, iter_cnt=0.
- Single survivor at load: nz=4'b0100 throughout, pulse start → done in cycle 3, winner=2, winner_valid=1, iter_cnt=0, pen_mult never asserted.
- Converging run: nz=4'b1111 until the 2nd WB, then 4'b0010 → done in cycle 11, iter_cnt=2, winner=1, winner_valid=1. Check the strobe order each iteration: pen_mult, then pen_cpa, then ld_x with sel_init=0.
- All lanes die: nz=4'b0011, then 4'b0000 after the 1st WB → done in cycle 7, winner_valid=0, timeout=0, iter_cnt=1.
- Timeout: MAX_ITER=3, nz=4'b1001 constant → done in cycle 15, timeout=1, winner_valid=0, iter_cnt=3.
- start while busy: pulse start during ADD and during DONE → no extra LOAD, and the run's done/iter_cnt are unaffected. A start in the following IDLE cycle is accepted, and LOAD clears the results.

Source files
------------

// File: rtl/maxnet_if.sv
// MaxNet controller handshake bundle.
// Master drives start/nz, slave is the controller.
interface maxnet_if #(
  parameter int NUM_PU = 4
) ();
  logic              start;
  logic [NUM_PU-1:0] nz;
  logic              sel_init;
  logic              ld_x;
  logic              pen_mult;
  logic              pen_cpa;
  logic              busy;
  logic              done;
  logic [1:0]        winner;
  logic              winner_valid;
  logic              timeout;
  logic [4:0]        iter_cnt;

  modport master (
    output start, nz,
    input  sel_init, ld_x, pen_mult, pen_cpa,
    input  busy, done, winner, winner_valid,
    input  timeout, iter_cnt
  );

  modport slave (
    input  start, nz,
    output sel_init, ld_x, pen_mult, pen_cpa,
    output busy, done, winner, winner_valid,
    output timeout, iter_cnt
  );
endinterface

// File: rtl/maxnet_controller.sv
// MaxNet array sequencer: load, mult/add/wb loops,
// winner detection on CHECK, one-cycle done pulse.
module maxnet_controller #(
  parameter int NUM_PU   = 4,
  parameter int MAX_ITER = 31
) (
  input  logic     clk,
  input  logic     rst,
  maxnet_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, MULT, ADD, WB, DONE
  } state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_ITER);

  state_t     state;
  logic [2:0] pop;
  logic [1:0] win_idx;

  // Lane popcount and index of the (highest) set lane.
  always_comb begin
    pop     = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (bus.nz[i]) begin
        pop     = pop + 3'd1;
        win_idx = 2'(i);
      end
    end
  end

  // State register with strobes registered on entry to
  // each state, so they are pure decodes of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.sel_init     <= 1'b0;
      bus.ld_x         <= 1'b0;
      bus.pen_mult     <= 1'b0;
      bus.pen_cpa      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.winner       <= '0;
      bus.winner_valid <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.iter_cnt     <= '0;
    end else begin
      bus.sel_init <= 1'b0;
      bus.ld_x     <= 1'b0;
      bus.pen_mult <= 1'b0;
      bus.pen_cpa  <= 1'b0;
      bus.done     <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (bus.start) begin
            state            <= LOAD;
            bus.sel_init     <= 1'b1;
            bus.ld_x         <= 1'b1;
            bus.busy         <= 1'b1;
            bus.iter_cnt     <= '0;
            bus.winner       <= '0;
            bus.winner_valid <= 1'b0;
            bus.timeout      <= 1'b0;
          end
        end
        LOAD: begin
          state <= CHECK;
        end
        CHECK: begin
          if (pop <= 3'd1) begin
            state            <= DONE;
            bus.done         <= 1'b1;
            bus.winner_valid <= (pop == 3'd1);
            bus.winner       <= (pop == 3'd1) ? win_idx : 2'd0;
            bus.timeout      <= 1'b0;
          end else if (bus.iter_cnt == MAX_CNT) begin
            state            <= DONE;
            bus.done         <= 1'b1;
            bus.winner       <= '0;
            bus.winner_valid <= 1'b0;
            bus.timeout      <= 1'b1;
          end else begin
            state        <= MULT;
            bus.pen_mult <= 1'b1;
          end
        end
        MULT: begin
          state       <= ADD;
          bus.pen_cpa <= 1'b1;
        end
        ADD: begin
          state    <= WB;
          bus.ld_x <= 1'b1;
        end
        WB: begin
          state <= CHECK;
          if (bus.iter_cnt != 5'd31)
            bus.iter_cnt <= bus.iter_cnt + 5'd1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
